wb_trace_buffer: RTL and testbench

Parametrised writeback trace capture unit for the 32-bit MIPS pipeline. Sits beside `top` and snoops the MEM/WB writeback stream (`MEMWB_RegWrite`, `MEMWB_DataResult`, `PCResult`). Records committed writes into a circular buffer, stops a programmable number of writes after a PC-match trigger, then replays the captured window oldest-first over a request/valid handshake.

---
 rtl/trace_pkg.sv | 31 +++
 rtl/wb_trace_buffer_if.sv | 17 +
 rtl/trace_ram.sv | 32 +++
 rtl/wb_trace_buffer.sv | 136 +++++++++++++
 tb/tb_wb_trace_buffer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared types and width helpers for the writeback trace buffer.
// Defining TRACE_HILO_EN widens every entry by the 64-bit hi/lo pair.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

`ifdef TRACE_HILO_EN
  localparam int HILO_W = 64;
`else
  localparam int HILO_W = 0;
`endif

  function automatic int entry_w(input int data_w, input int pc_w);
    return pc_w + data_w + HILO_W;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a completely full buffer (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Readout handshake of the trace buffer: request in, one-cycle-later entry out.
// Entry width follows trace_pkg::entry_w, so it grows when TRACE_HILO_EN is defined.
interface wb_trace_buffer_if
  import trace_pkg::*;
#(
  parameter int ENTRY_W = entry_w(32, 32)
) ();

  logic               RdReq;
  logic               RdValid;
  logic [ENTRY_W-1:0] RdData;
  logic               RdLast;

  modport master (output RdReq, input RdValid, input RdData, input RdLast);
  modport slave  (input RdReq, output RdValid, output RdData, output RdLast);

endinterface

// File: rtl/trace_ram.sv
// Single-write, single-read synchronous trace store with a registered read port.
// The read register returns to zero on cycles without a read so data is only ever seen with its valid.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    re,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata_p1
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read stage p0 -> p1
  always_ff @(posedge clk) begin
    if (!reset_n)  rdata_p1 <= '0;
    else if (re)   rdata_p1 <= mem[raddr];
    else           rdata_p1 <= '0;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: circular capture until POST_TRIG writes after a PC match, then oldest-first replay.
// Defining TRACE_HILO_EN adds ALUhi/ALUlo inputs stored alongside each entry.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   MEMWB_RegWrite,
  input  logic [DATA_W-1:0]      MEMWB_DataResult,
  input  logic [PC_W-1:0]        PCResult,
`ifdef TRACE_HILO_EN
  input  logic [31:0]            ALUhi,
  input  logic [31:0]            ALUlo,
`endif
  input  logic                   Arm,
  input  logic                   Abort,
  input  logic [PC_W-1:0]        TrigPC,
  wb_trace_buffer_if.slave       rd,
  output logic [1:0]             State,
  output logic [$clog2(DEPTH):0] Fill
);

  localparam int EW = entry_w(DATA_W, PC_W);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_TRIG);

  state_t        state;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt;
  logic [CW-1:0] fill, post_cnt, rd_cnt, fill_nxt, post_nxt;
  logic          trig, wr, rd_fire, last_rd;
  logic          vld_p1, last_p1;
  logic [EW-1:0] wdata, rdata_p1;

  always_comb begin
    trig       = (PCResult == TrigPC);
    wr         = MEMWB_RegWrite && ((state == ST_ARMED) || (state == ST_POST));
    rd_fire    = rd.RdReq && (state == ST_DONE) && !Abort;
    last_rd    = ((rd_cnt + CW'(1)) == fill);
    wr_ptr_nxt = wr ? wr_ptr + PW'(1) : wr_ptr;
    fill_nxt   = (wr && (fill != FULL)) ? fill + CW'(1) : fill;
    // In ARMED the trigger-cycle write is post-trigger write number one.
    post_nxt   = ((state == ST_POST) ? post_cnt : '0) + (wr ? CW'(1) : CW'(0));
`ifdef TRACE_HILO_EN
    wdata      = {PCResult, MEMWB_DataResult, ALUhi, ALUlo};
`else
    wdata      = {PCResult, MEMWB_DataResult};
`endif
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk      (Clk),
    .reset_n  (Reset),
    .we       (wr && Reset && !Abort),
    .waddr    (wr_ptr),
    .wdata    (wdata),
    .re       (rd_fire && Reset),
    .raddr    (rd_ptr),
    .rdata_p1 (rdata_p1)
  );

  // Control stage p0 -> p1
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1  <= rd_fire;
      last_p1 <= rd_fire && last_rd;
      if (Abort) begin
        state    <= ST_IDLE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fill     <= '0;
        post_cnt <= '0;
        rd_cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (Arm) begin
              state    <= ST_ARMED;
              fill     <= '0;
              wr_ptr   <= '0;
              post_cnt <= '0;
            end
          end
          ST_ARMED, ST_POST: begin
            wr_ptr <= wr_ptr_nxt;
            fill   <= fill_nxt;
            if ((state == ST_POST) || trig) begin
              post_cnt <= post_nxt;
              if (post_nxt == POST_LAST) begin
                state  <= ST_DONE;
                // Oldest entry sits Fill slots behind the write pointer.
                rd_ptr <= wr_ptr_nxt - fill_nxt[PW-1:0];
                rd_cnt <= '0;
              end else begin
                state <= ST_POST;
              end
            end
          end
          ST_DONE: begin
            if (rd_fire) begin
              rd_ptr <= rd_ptr + PW'(1);
              rd_cnt <= rd_cnt + CW'(1);
              if (last_rd) state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd.RdValid = vld_p1;
  assign rd.RdLast  = last_p1;
  assign rd.RdData  = rdata_p1;
  assign State      = state;
  assign Fill       = fill;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer (DEPTH=8, POST_TRIG=4); hi/lo fields are checked when TRACE_HILO_EN is defined.
module tb_wb_trace_buffer;
  import trace_pkg::*;

  localparam int DATA_W    = 32;
  localparam int PC_W      = 32;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 4;
  localparam int EW        = entry_w(DATA_W, PC_W);
  localparam logic [31:0] IDLE_PC = 32'hFFFF_FFF0;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              MEMWB_RegWrite = 1'b0;
  logic [DATA_W-1:0] MEMWB_DataResult = '0;
  logic [PC_W-1:0]   PCResult = IDLE_PC;
`ifdef TRACE_HILO_EN
  logic [31:0]       ALUhi = '0;
  logic [31:0]       ALUlo = '0;
`endif
  logic              Arm = 1'b0;
  logic              Abort = 1'b0;
  logic [PC_W-1:0]   TrigPC = 32'h0000_000C;
  logic [1:0]        State;
  logic [3:0]        Fill;

  wb_trace_buffer_if #(.ENTRY_W(EW)) rd_if ();

  wb_trace_buffer #(
    .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .MEMWB_RegWrite   (MEMWB_RegWrite),
    .MEMWB_DataResult (MEMWB_DataResult),
    .PCResult         (PCResult),
`ifdef TRACE_HILO_EN
    .ALUhi            (ALUhi),
    .ALUlo            (ALUlo),
`endif
    .Arm              (Arm),
    .Abort            (Abort),
    .TrigPC           (TrigPC),
    .rd               (rd_if),
    .State            (State),
    .Fill             (Fill)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [EW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

`ifdef TRACE_HILO_EN
  function automatic logic [31:0] hi_of(input logic [31:0] d);
    return d * 32'd3 + 32'h0000_1000;
  endfunction
  function automatic logic [31:0] lo_of(input logic [31:0] d);
    return ~d;
  endfunction
`endif

  function automatic logic [EW-1:0] exp_entry(input logic [31:0] pc, input logic [31:0] d);
`ifdef TRACE_HILO_EN
    return {pc, d, hi_of(d), lo_of(d)};
`else
    return {pc, d};
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every presented entry must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (rd_if.RdValid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry actual=%0h required=none", rd_if.RdData);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_data", rd_if.RdData, mon_e.data);
        chk("rd_last", rd_if.RdLast, mon_e.last);
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] pc, input logic [31:0] d);
    MEMWB_RegWrite   = 1'b1;
    PCResult         = pc;
    MEMWB_DataResult = d;
`ifdef TRACE_HILO_EN
    ALUhi = hi_of(d);
    ALUlo = lo_of(d);
`endif
    cyc();
    MEMWB_RegWrite = 1'b0;
    PCResult       = IDLE_PC;
  endtask

  task automatic arm();
    Arm = 1'b1;
    cyc();
    Arm = 1'b0;
  endtask

  task automatic read_one(input logic [31:0] pc, input logic [31:0] d, input logic last);
    sb.push_back('{data: exp_entry(pc, d), last: last});
    rd_if.RdReq = 1'b1;
    cyc();
    rd_if.RdReq = 1'b0;
    cyc();
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    cyc();
    Reset = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdvalid"}, rd_if.RdValid, 0);
    chk({tag, "_rddata"}, rd_if.RdData, 0);
    chk({tag, "_rdlast"}, rd_if.RdLast, 0);
    chk({tag, "_state"}, State, 0);
    chk({tag, "_fill"}, Fill, 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_pending"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_if.RdReq = 1'b0;
    repeat (2) cyc();
    chk_zero("reset");
    Reset = 1'b1;
    cyc();

    // Basic capture, no wrap
    TrigPC = 32'h0000_000C;
    arm();
    chk("basic_armed", State, 1);
    wr(32'h00, 1); wr(32'h04, 2); wr(32'h08, 3);
    chk("basic_fill3", Fill, 3);
    wr(32'h0C, 4);
    chk("basic_post", State, 2);
    wr(32'h10, 5); wr(32'h14, 6);
    chk("basic_still_post", State, 2);
    wr(32'h18, 7);
    chk("basic_done", State, 3);
    chk("basic_fill7", Fill, 7);
    for (int d = 1; d <= 7; d++) read_one(32'((d - 1) * 4), 32'(d), d == 7);
    chk("basic_idle", State, 0);
    drain("basic");

    // Wrap / overwrite with a back-to-back burst
    TrigPC = 32'h0000_0144;
    arm();
    for (int d = 1; d <= 20; d++) wr(32'h100 + 32'(4 * d), 32'(d));
    chk("wrap_done", State, 3);
    chk("wrap_fill", Fill, 8);
    for (int d = 13; d <= 20; d++)
      sb.push_back('{data: exp_entry(32'h100 + 32'(4 * d), 32'(d)), last: (d == 20)});
    rd_if.RdReq = 1'b1;
    repeat (8) cyc();
    rd_if.RdReq = 1'b0;
    chk("wrap_idle", State, 0);
    drain("wrap");

    // Trigger on a cycle without a write, plus ignored requests
    TrigPC = 32'h0000_0200;
    arm();
    rd_if.RdReq = 1'b1;
    cyc();
    rd_if.RdReq = 1'b0;
    chk("armed_rdreq_ignored", rd_if.RdValid, 0);
    for (int d = 1; d <= 5; d++) wr(32'h300 + 32'(4 * d), 32'(d));
    PCResult = 32'h0000_0200;
    cyc();
    PCResult = IDLE_PC;
    chk("nowr_post", State, 2);
    chk("nowr_fill5", Fill, 5);
    for (int d = 6; d <= 9; d++) wr(32'h300 + 32'(4 * d), 32'(d));
    chk("nowr_done", State, 3);
    chk("nowr_fill8", Fill, 8);
    arm();
    chk("arm_in_done_ignored", State, 3);
    for (int d = 2; d <= 9; d++) read_one(32'h300 + 32'(4 * d), 32'(d), d == 9);
    chk("nowr_idle", State, 0);
    drain("nowr");

    // Abort beats Arm
    arm();
    wr(32'h400, 1); wr(32'h404, 2);
    chk("abort_pre_fill", Fill, 2);
    Arm = 1'b1; Abort = 1'b1;
    cyc();
    Arm = 1'b0; Abort = 1'b0;
    chk("abort_state", State, 0);
    chk("abort_fill", Fill, 0);

    // Reset during POST
    TrigPC = 32'h0000_0500;
    arm();
    wr(32'h4F8, 1); wr(32'h500, 2);
    chk("rst_post_state", State, 2);
    pulse_reset();
    chk_zero("rst_post");

    // Reset during readout
    arm();
    wr(32'h4F0, 1); wr(32'h4F4, 2); wr(32'h500, 3);
    wr(32'h504, 4); wr(32'h508, 5); wr(32'h50C, 6);
    chk("rst_rd_done", State, 3);
    chk("rst_rd_fill", Fill, 6);
    read_one(32'h4F0, 1, 1'b0);
    read_one(32'h4F4, 2, 1'b0);
    pulse_reset();
    chk_zero("rst_rd");
    drain("rst_rd");

    // Clean re-arm after reset, trigger on first write
    arm();
    chk("rearm_fill", Fill, 0);
    for (int d = 1; d <= 4; d++) wr(32'h500 + 32'(4 * (d - 1)), 32'(d));
    chk("rearm_done", State, 3);
    chk("rearm_fill4", Fill, 4);
    for (int d = 1; d <= 4; d++)
      sb.push_back('{data: exp_entry(32'h500 + 32'(4 * (d - 1)), 32'(d)), last: (d == 4)});
    rd_if.RdReq = 1'b1;
    repeat (4) cyc();
    rd_if.RdReq = 1'b0;
    chk("rearm_idle", State, 0);
    drain("rearm");

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
